// File: rtl/program_memory_pkg.sv
// Shared definitions for the loadable program memory.
// NOP encoding, loader FSM states and default widths.
package program_memory_pkg;

  localparam int PM_DATA_W = 32;
  localparam int PM_ADDR_W = 8;
  localparam int PM_LOAD_W = 8;

  localparam logic [PM_DATA_W-1:0] PM_NOP = '0;

  typedef enum logic [1:0] {
    PM_IDLE = 2'd0,
    PM_LOAD = 2'd1,
    PM_DONE = 2'd2
  } pm_state_t;

endpackage

// File: rtl/program_memory_if.sv
// Byte-stream loader port of the program memory.
// Carries the start request, base address and valid/ready byte stream.
interface program_memory_if #(
  parameter int ADDR_W = 8,
  parameter int LOAD_W = 8
);

  logic              load_start;
  logic [ADDR_W-1:0] load_base;
  logic [LOAD_W-1:0] load_data;
  logic              load_valid;
  logic              load_last;
  logic              load_ready;

  modport master (
    output load_start, load_base, load_data,
    output load_valid, load_last,
    input  load_ready
  );

  modport slave (
    input  load_start, load_base, load_data,
    input  load_valid, load_last,
    output load_ready
  );

endinterface

// File: rtl/program_memory_word_assembler.sv
// Packs big-endian loader bytes into instruction words.
// A last byte flushes the word with its low bytes zero-filled.
module program_memory_word_assembler
  import program_memory_pkg::*;
#(
  parameter int DATA_W = PM_DATA_W,
  parameter int LOAD_W = PM_LOAD_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              accept,
  input  logic [LOAD_W-1:0] data_in,
  input  logic              last,
  output logic [DATA_W-1:0] word,
  output logic              word_write,
  output logic              word_last
);

  localparam int BPW   = DATA_W / LOAD_W;
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_buf;
  logic              w_full;

  assign w_full     = (r_idx == IDX_W'(BPW - 1));
  assign word_write = accept && (w_full || last);
  assign word_last  = accept && last;

  // The current byte is merged in combinationally so the write lands on its edge
  always_comb begin
    word = r_buf;
    word[(BPW - 1 - int'(r_idx)) * LOAD_W +: LOAD_W] = data_in;
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_idx <= '0;
      r_buf <= '0;
    end else if (word_write) begin
      r_idx <= '0;
      r_buf <= '0;
    end else if (accept) begin
      r_idx <= r_idx + 1'b1;
      r_buf <= word;
    end
  end

endmodule

// File: rtl/program_memory.sv
// Run-time loadable instruction store with registered fetch.
// Optional PMEM_BOUNDS_CHECK_EN adds range checks and a sticky fault.
module program_memory
  import program_memory_pkg::*;
#(
  parameter int DATA_W = PM_DATA_W,
  parameter int ADDR_W = PM_ADDR_W,
  parameter int DEPTH  = 256,
  parameter int LOAD_W = PM_LOAD_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              fetch_en,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid,
  program_memory_if.slave   ld,
  output logic              busy,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count,
  output logic              fault
);

  pm_state_t r_state;
  pm_state_t w_next;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_instr;
  logic              r_valid;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W:0]   r_count;

  logic              w_base_ok;
  logic              w_start;
  logic              w_accept;
  logic [DATA_W-1:0] w_word;
  logic              w_word_write;
  logic              w_word_last;

`ifdef PMEM_BOUNDS_CHECK_EN
  logic r_fault;
  logic w_addr_ok;

  assign w_base_ok = 32'(ld.load_base) < DEPTH;
  assign w_addr_ok = 32'(address) < DEPTH;
  assign fault     = r_fault;

  always_ff @(posedge clock) begin
    if (reset)
      r_fault <= 1'b0;
    else if (r_state == PM_IDLE && ((fetch_en && !w_addr_ok) ||
             (ld.load_start && !w_base_ok)))
      r_fault <= 1'b1;
  end
`else
  assign w_base_ok = 1'b1;
  assign fault     = 1'b0;
`endif

  assign w_start       = (r_state == PM_IDLE) && ld.load_start && w_base_ok;
  assign ld.load_ready = (r_state == PM_LOAD);
  assign w_accept      = ld.load_valid && ld.load_ready;
  assign busy          = (r_state != PM_IDLE);
  assign load_done     = (r_state == PM_DONE);
  assign load_count    = r_count;
  assign instruction   = r_instr;
  assign instr_valid   = r_valid;

  program_memory_word_assembler #(
    .DATA_W (DATA_W),
    .LOAD_W (LOAD_W)
  ) u_asm (
    .clock      (clock),
    .reset      (reset),
    .clear      (w_start),
    .accept     (w_accept),
    .data_in    (ld.load_data),
    .last       (ld.load_last),
    .word       (w_word),
    .word_write (w_word_write),
    .word_last  (w_word_last)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      PM_IDLE: if (w_start)     w_next = PM_LOAD;
      PM_LOAD: if (w_word_last) w_next = PM_DONE;
      PM_DONE:                  w_next = PM_IDLE;
      default:                  w_next = PM_IDLE;
    endcase
  end

  // Array is never reset so words written before a reset survive it
  always_ff @(posedge clock) begin
    if (!reset && w_word_write)
      r_mem[r_wr_addr] <= w_word;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= PM_IDLE;
      r_wr_addr <= '0;
      r_count   <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_wr_addr <= ld.load_base;
        r_count   <= '0;
      end else if (w_word_write) begin
        r_wr_addr <= (r_wr_addr == ADDR_W'(DEPTH - 1)) ?
                     '0 : r_wr_addr + 1'b1;
        if (r_count != '1)
          r_count <= r_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_instr <= PM_NOP;
      r_valid <= 1'b0;
    end else if (r_state != PM_IDLE) begin
      r_instr <= PM_NOP;
      r_valid <= 1'b0;
    end else if (fetch_en) begin
      r_valid <= 1'b1;
`ifdef PMEM_BOUNDS_CHECK_EN
      r_instr <= w_addr_ok ? r_mem[address] : PM_NOP;
`else
      r_instr <= r_mem[address];
`endif
    end else begin
      r_valid <= 1'b0;
    end
  end

endmodule
